// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared types for the two-entry cache store buffer: occupancy state and the
// default-width entry layout {addr, data, mask}.
package bsg_cache_sbuf_pkg;

    localparam int sbuf_data_width_lp = 64;
    localparam int sbuf_addr_width_lp = 32;
    localparam int sbuf_mask_width_lp = sbuf_data_width_lp / 8;

    typedef enum logic [1:0] {
        e_sbuf_empty = 2'd0,
        e_sbuf_one   = 2'd1,
        e_sbuf_full  = 2'd2
    } sbuf_state_e;

    typedef struct packed {
        logic [sbuf_addr_width_lp-1:0] addr;
        logic [sbuf_data_width_lp-1:0] data;
        logic [sbuf_mask_width_lp-1:0] mask;
    } sbuf_entry_s;

endpackage

// File: rtl/bsg_cache_sbuf_if.sv
// Store-buffer port bundle: enqueue, head dequeue (valid/yumi) and bypass lookup.
// The slave modport is the buffer side; the master modport is the cache side.
interface bsg_cache_sbuf_if #(
    parameter int data_width_p = 64,
    parameter int addr_width_p = 32
);
    localparam int mask_width_lp = data_width_p / 8;

    logic                     v_i;
    logic [addr_width_p-1:0]  addr_i;
    logic [data_width_p-1:0]  data_i;
    logic [mask_width_lp-1:0] mask_i;
    logic                     full_o;
    logic                     empty_o;
    logic                     v_o;
    logic [addr_width_p-1:0]  addr_o;
    logic [data_width_p-1:0]  data_o;
    logic [mask_width_lp-1:0] mask_o;
    logic                     yumi_i;
    logic                     bypass_v_i;
    logic [addr_width_p-1:0]  bypass_addr_i;
    logic [data_width_p-1:0]  bypass_data_o;
    logic [mask_width_lp-1:0] bypass_mask_o;

    modport slave (
        input  v_i, addr_i, data_i, mask_i, yumi_i, bypass_v_i, bypass_addr_i,
        output full_o, empty_o, v_o, addr_o, data_o, mask_o, bypass_data_o, bypass_mask_o
    );

    modport master (
        output v_i, addr_i, data_i, mask_i, yumi_i, bypass_v_i, bypass_addr_i,
        input  full_o, empty_o, v_o, addr_o, data_o, mask_o, bypass_data_o, bypass_mask_o
    );

endinterface

// File: rtl/bsg_cache_sbuf_queue.sv
// Two-element queue datapath: el1 is the head, el0 the tail; enables and mux
// selects come from the controller. Storage is intentionally not reset.
module bsg_cache_sbuf_queue #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               el0_en_i,
    input  logic               el1_en_i,
    input  logic               mux0_sel_i,
    input  logic               mux1_sel_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] el0_snoop_o,
    output logic [width_p-1:0] el1_snoop_o,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] el0_q, el0_d;
    logic [width_p-1:0] el1_q, el1_d;

    // mux0_sel promotes the tail into the head when the head drains at count 2
    always_comb begin
        el0_d = el0_en_i ? data_i : el0_q;
        el1_d = el1_en_i ? (mux0_sel_i ? el0_q : data_i) : el1_q;
    end

    always_ff @(posedge clk_i) begin
        el0_q <= el0_d;
        el1_q <= el1_d;
    end

    assign el0_snoop_o = el0_q;
    assign el1_snoop_o = el1_q;
    assign data_o      = mux1_sel_i ? el1_q : data_i;

endmodule

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Two-entry store buffer controller: occupancy FSM drives a data queue and an
// addr/mask queue, plus a combinational per-byte bypass for later loads.
module bsg_cache_sbuf_ctrl
    import bsg_cache_sbuf_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int addr_width_p = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    bsg_cache_sbuf_if.slave sbuf
);

    localparam int mask_width_lp = data_width_p / 8;
    localparam int lg_mask_lp    = $clog2(mask_width_lp);
    localparam int am_width_lp   = addr_width_p + mask_width_lp;

    sbuf_state_e count_q, count_d;

    logic el0_en, el1_en, mux0_sel, mux1_sel;

    logic [data_width_p-1:0] el0_data, el1_data, head_data;
    logic [am_width_lp-1:0]  el0_am, el1_am, head_am;

    always_comb begin
        count_d  = count_q;
        el0_en   = 1'b0;
        el1_en   = 1'b0;
        mux0_sel = 1'b0;
        mux1_sel = (count_q != e_sbuf_empty);
        unique case (count_q)
            e_sbuf_empty: begin
                // v_i & yumi_i consumes the store in passing with no writes
                if (sbuf.v_i && !sbuf.yumi_i) begin
                    el1_en  = 1'b1;
                    count_d = e_sbuf_one;
                end
            end
            e_sbuf_one: begin
                if (sbuf.v_i && sbuf.yumi_i) begin
                    el1_en = 1'b1;
                end else if (sbuf.v_i) begin
                    el0_en  = 1'b1;
                    count_d = e_sbuf_full;
                end else if (sbuf.yumi_i) begin
                    count_d = e_sbuf_empty;
                end
            end
            e_sbuf_full: begin
                if (sbuf.yumi_i) begin
                    el1_en   = 1'b1;
                    mux0_sel = 1'b1;
                    count_d  = e_sbuf_one;
                end
            end
            default: count_d = e_sbuf_empty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= e_sbuf_empty;
        else         count_q <= count_d;
    end

    bsg_cache_sbuf_queue #(.width_p(data_width_p)) data_queue (
        .clk_i       (clk_i),
        .el0_en_i    (el0_en),
        .el1_en_i    (el1_en),
        .mux0_sel_i  (mux0_sel),
        .mux1_sel_i  (mux1_sel),
        .data_i      (sbuf.data_i),
        .el0_snoop_o (el0_data),
        .el1_snoop_o (el1_data),
        .data_o      (head_data)
    );

    bsg_cache_sbuf_queue #(.width_p(am_width_lp)) am_queue (
        .clk_i       (clk_i),
        .el0_en_i    (el0_en),
        .el1_en_i    (el1_en),
        .mux0_sel_i  (mux0_sel),
        .mux1_sel_i  (mux1_sel),
        .data_i      ({sbuf.addr_i, sbuf.mask_i}),
        .el0_snoop_o (el0_am),
        .el1_snoop_o (el1_am),
        .data_o      (head_am)
    );

    assign sbuf.v_o     = (count_q == e_sbuf_empty) ? sbuf.v_i : 1'b1;
    assign sbuf.data_o  = head_data;
    assign sbuf.addr_o  = head_am[am_width_lp-1:mask_width_lp];
    assign sbuf.mask_o  = head_am[mask_width_lp-1:0];
    assign sbuf.full_o  = (count_q == e_sbuf_full);
    assign sbuf.empty_o = (count_q == e_sbuf_empty);

    logic [addr_width_p-1:0]  el0_addr, el1_addr;
    logic [mask_width_lp-1:0] el0_mask, el1_mask;
    logic                     el0_hit, el1_hit;

    assign el0_addr = el0_am[am_width_lp-1:mask_width_lp];
    assign el1_addr = el1_am[am_width_lp-1:mask_width_lp];
    assign el0_mask = el0_am[mask_width_lp-1:0];
    assign el1_mask = el1_am[mask_width_lp-1:0];

    assign el0_hit = (count_q == e_sbuf_full)
        && (el0_addr[addr_width_p-1:lg_mask_lp] == sbuf.bypass_addr_i[addr_width_p-1:lg_mask_lp]);
    assign el1_hit = (count_q != e_sbuf_empty)
        && (el1_addr[addr_width_p-1:lg_mask_lp] == sbuf.bypass_addr_i[addr_width_p-1:lg_mask_lp]);

    // el0 is the younger store, so it wins any byte both entries write
    always_comb begin
        sbuf.bypass_data_o = '0;
        sbuf.bypass_mask_o = '0;
        if (sbuf.bypass_v_i) begin
            for (int i = 0; i < mask_width_lp; i++) begin
                if (el0_hit && el0_mask[i]) begin
                    sbuf.bypass_data_o[i*8+:8] = el0_data[i*8+:8];
                    sbuf.bypass_mask_o[i]      = 1'b1;
                end else if (el1_hit && el1_mask[i]) begin
                    sbuf.bypass_data_o[i*8+:8] = el1_data[i*8+:8];
                    sbuf.bypass_mask_o[i]      = 1'b1;
                end
            end
        end
    end

    a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(sbuf.v_i && count_q == e_sbuf_full));
    a_no_yumi_without_v: assert property (@(posedge clk_i) disable iff (reset_i)
        !(sbuf.yumi_i && !sbuf.v_o));

endmodule

// File: tb/tb_bsg_cache_sbuf_ctrl.sv
// Scoreboard bench for the two-entry store buffer: stimulus pushes accepted
// stores, a negedge monitor checks head, flags and pops on yumi.
module tb_bsg_cache_sbuf_ctrl;
    import bsg_cache_sbuf_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    bsg_cache_sbuf_if #(.data_width_p(64), .addr_width_p(32)) sif ();

    bsg_cache_sbuf_ctrl #(.data_width_p(64), .addr_width_p(32)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sbuf    (sif)
    );

    sbuf_entry_s exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int occ     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: flags against scoreboard occupancy, head against oldest entry
    always @(negedge clk_i) begin
        if (!reset_i) begin
            int o;
            o = exp_q.size() - (sif.v_i ? 1 : 0);
            check("full_o", 64'(sif.full_o), 64'(o == 2));
            check("empty_o", 64'(sif.empty_o), 64'(o == 0));
            check("v_o", 64'(sif.v_o), 64'((o > 0) || sif.v_i));
            if (sif.v_o) begin
                if (exp_q.size() == 0) begin
                    check("head_present", 64'(0), 64'(1));
                end else begin
                    check("head_data", sif.data_o, exp_q[0].data);
                    check("head_addr", 64'(sif.addr_o), 64'(exp_q[0].addr));
                    check("head_mask", 64'(sif.mask_o), 64'(exp_q[0].mask));
                    if (sif.yumi_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] m, input logic y);
        sbuf_entry_s e;
        sif.v_i    = v;
        sif.addr_i = a;
        sif.data_i = d;
        sif.mask_i = m;
        sif.yumi_i = y;
        if (v) begin
            e.addr = a; e.data = d; e.mask = m;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        occ = occ + (v ? 1 : 0) - (y ? 1 : 0);
        sif.v_i    = 1'b0;
        sif.yumi_i = 1'b0;
    endtask

    task automatic do_reset(input logic y);
        reset_i    = 1'b1;
        sif.v_i    = 1'b0;
        sif.yumi_i = y;
        exp_q.delete();
        occ = 0;
        @(posedge clk_i);
        #1;
        reset_i    = 1'b0;
        sif.yumi_i = 1'b0;
    endtask

    task automatic lookup(input string name, input logic bv, input logic [31:0] a,
                          input logic [7:0] m_exp, input logic [63:0] d_exp);
        sif.bypass_v_i    = bv;
        sif.bypass_addr_i = a;
        #1;
        check({name, "_mask"}, 64'(sif.bypass_mask_o), 64'(m_exp));
        check({name, "_data"}, sif.bypass_data_o, d_exp);
        sif.bypass_v_i = 1'b0;
    endtask

    initial begin
        logic v, y;
        sif.v_i = 1'b0; sif.addr_i = '0; sif.data_i = '0; sif.mask_i = '0;
        sif.yumi_i = 1'b0; sif.bypass_v_i = 1'b0; sif.bypass_addr_i = '0;
        @(posedge clk_i); #1;
        do_reset(1'b0);

        // Reset state
        check("rst_empty", 64'(sif.empty_o), 64'(1));
        check("rst_full", 64'(sif.full_o), 64'(0));
        check("rst_v_o", 64'(sif.v_o), 64'(0));
        lookup("rst_byp", 1'b1, 32'h100, 8'h00, 64'h0);

        // Pass-through: enqueue and consume in the same cycle
        drive(1'b1, 32'h100, 64'h11, 8'hFF, 1'b1);
        check("pass_empty", 64'(sif.empty_o), 64'(1));
        drive(1'b0, 32'h0, 64'h0, 8'h0, 1'b0);

        // Fill with A then B, drain one at a time
        drive(1'b1, 32'h100, 64'hA, 8'hFF, 1'b0);
        drive(1'b1, 32'h108, 64'hB, 8'hFF, 1'b0);
        check("ab_full", 64'(sif.full_o), 64'(1));
        check("ab_head", sif.data_o, 64'hA);
        drive(1'b0, 32'h0, 64'h0, 8'h0, 1'b1);
        check("ab_head2", sif.data_o, 64'hB);
        drive(1'b0, 32'h0, 64'h0, 8'h0, 1'b1);
        check("ab_empty", 64'(sif.empty_o), 64'(1));

        // Count 1 with simultaneous enqueue and dequeue
        drive(1'b1, 32'h300, 64'hC0, 8'h0F, 1'b0);
        for (int i = 1; i <= 5; i++)
            drive(1'b1, 32'h300 + 32'(i * 8), 64'hC0 + 64'(i), 8'h0F, 1'b1);
        check("c_one", 64'(sif.full_o | sif.empty_o), 64'(0));
        check("c_head", sif.data_o, 64'hC5);
        drive(1'b0, 32'h0, 64'h0, 8'h0, 1'b1);

        // Bypass merge, el0 newest wins byte 1
        drive(1'b1, 32'h200, 64'hAAAA, 8'h03, 1'b0);
        drive(1'b1, 32'h204, 64'hBB00, 8'h02, 1'b0);
        lookup("byp_200", 1'b1, 32'h200, 8'h03, 64'hBBAA);
        lookup("byp_207", 1'b1, 32'h207, 8'h03, 64'hBBAA);
        lookup("byp_miss", 1'b1, 32'h208, 8'h00, 64'h0);
        lookup("byp_off", 1'b0, 32'h200, 8'h00, 64'h0);

        // Reset wins over yumi at full
        do_reset(1'b1);
        check("rstf_empty", 64'(sif.empty_o), 64'(1));
        check("rstf_v_o", 64'(sif.v_o), 64'(0));
        lookup("rstf_byp", 1'b1, 32'h200, 8'h00, 64'h0);

        // Random legal traffic
        for (int i = 0; i < 10000; i++) begin
            v = (occ < 2) && ($urandom_range(0, 1) == 1);
            y = ((occ > 0) || v) && ($urandom_range(0, 2) != 0);
            drive(v, $urandom, {$urandom, $urandom}, 8'($urandom), y);
        end
        for (int i = 0; i < 4; i++)
            if (occ > 0) drive(1'b0, 32'h0, 64'h0, 8'h0, 1'b1);
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_cache_sbuf_ctrl.md
Name: bsg_cache_sbuf_ctrl

Overview:
Two-entry store buffer for the cache. The block sequences a pair of two-element queue datapaths: one holds store data, the other holds store address and byte mask. It generates the element enables and mux selects from an occupancy state machine. It also provides a combinational bypass port so a later load can read bytes still pending in the buffer.

Parameters:
data_width_p, 64, store data width in bits.
addr_width_p, 32, byte address width.
mask_width_p, data_width_p/8, byte-mask width (derived; not overridden).

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous active-high reset.
v_i  in  1  store enqueue request.
addr_i  in  addr_width_p  store byte address.
data_i  in  data_width_p  store data.
mask_i  in  mask_width_p  store byte mask.
full_o  out  1  two entries valid; v_i must not be asserted.
empty_o  out  1  no entries valid.
v_o  out  1  head store valid.
addr_o  out  addr_width_p  head address.
data_o  out  data_width_p  head data.
mask_o  out  mask_width_p  head mask.
yumi_i  in  1  head consumed this cycle; legal only when v_o=1.
bypass_v_i  in  1  bypass lookup valid.
bypass_addr_i  in  addr_width_p  lookup byte address.
bypass_data_o  out  data_width_p  merged pending bytes.
bypass_mask_o  out  mask_width_p  bytes supplied by the buffer.

Behaviour:
- State: count_r in {0,1,2}. el1 is the head, el0 is the tail.
  - count 0: both entries empty.
  - count 1: el1 valid.
  - count 2: el1 and el0 valid.
- Reset: count_r=0, so empty_o=1, full_o=0, v_o=0, bypass_mask_o=0. Storage is not reset. Reset overrides any simultaneous v_i/yumi_i.
- Datapath controls (same for both queue instances):
  - mux1_sel = (count_r!=0).
  - el0_en, el1_en and mux0_sel are set per the state rules below.
  - Defaults: enables 0, mux0_sel=0.
- Head output:
  - count 0: pass-through. v_o=v_i, head fields = inputs; zero-latency bypass of the store.
  - count 1 or 2: v_o=1, head fields = el1.
- count 0 transitions:
  - v_i & yumi_i: consumed in passing; stay 0, no enables.
  - v_i & ~yumi_i: el1_en=1 (loads input), go to 1.
- count 1 transitions:
  - v_i & yumi_i: el1_en=1, mux0_sel=0; stay 1.
  - v_i & ~yumi_i: el0_en=1; go to 2.
  - ~v_i & yumi_i: go to 0.
- count 2 transitions:
  - yumi_i: el1_en=1, mux0_sel=1 (el1<=el0); go to 1.
  - v_i: illegal. Simulation assertion; ignored, no enables.
- full_o = (count_r==2); empty_o = (count_r==0). Both are registered-state derived, with no path from v_i or yumi_i.
- yumi_i with v_o=0 is illegal (assertion); state is unchanged.
- Bypass (combinational, word granularity):
  - Match = address bits [addr_width_p-1 : log2(mask_width_p)] equal and the entry is valid.
  - Per byte: if el0 matches and its mask bit is set, take the el0 byte (newest wins). Else if el1 matches and its mask bit is set, take the el1 byte. Else the byte is 0 with mask bit 0.
  - bypass_v_i=0 forces bypass_mask_o=0 and bypass_data_o=0.
  - The current-cycle v_i is not included in bypass.

Decomposition:
- Shared package bsg_cache_sbuf_pkg holds:
  - the count state enum (e_sbuf_empty, e_sbuf_one, e_sbuf_full);
  - the entry struct {addr, data, mask}.
- Sub-module: bsg_cache_sbuf_queue, instantiated twice (data width; addr+mask width), sharing identical control signals.
- Per-byte bypass merge stays inline.

Test Plan:
- Reset, then v_i=1 addr=0x100 data=0x11 mask=0xFF yumi_i=1 in the same cycle -> v_o=1, data_o=0x11 that cycle; count stays 0, empty_o=1 next cycle.
- Enqueue A(0x100) then B(0x108) with no yumi_i -> full_o=1, data_o=A. Pulse yumi_i -> data_o=B, count 1. Pulse yumi_i -> empty_o=1.
- At count 1, v_i=C and yumi_i together each cycle for 5 cycles -> count stays 1, each value appears on data_o exactly one cycle later, in order.
- el1 = addr 0x200, data 0x..AAAA, mask 0x03; el0 = addr 0x204, data 0x..BB00, mask 0x02; lookup bypass_addr_i=0x200 -> bypass_mask_o=0x03, bytes[1:0]=0xBBAA (el0 wins byte 1).
- Full buffer; assert reset_i with yumi_i=1 -> next cycle empty_o=1, v_o=0, bypass_mask_o=0 for any lookup.
- Random v_i/yumi_i obeying the legality rules for 10k cycles against a 2-entry FIFO model -> output order, full_o and empty_o match every cycle.
